starship_rom_ctrl: RTL and testbench

// Parametrised read-only boot/mask memory with valid/ready request and response channels.

---
 rtl/starship_rom_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_starship_rom_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/starship_rom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : starship_rom_ctrl
//  Purpose  : Parametrised read-only boot/mask memory with valid/ready
//             request and response channels. The word array is read on
//             request accept and passes through a 1- or 2-stage pipeline.
//             Results land in a credit-limited response queue.
//             Requests whose word index falls outside DEPTH return
//             rsp_err_o=1 with zero data.
//  Ports    : clock_i      - sole clock, posedge
//             reset_i      - asynchronous active-high reset (control state only)
//             req_valid_i  - read request present
//             req_ready_o  - request can be accepted this cycle
//             req_addr_i   - byte address, sub-word bits ignored
//             rsp_valid_o  - response present at queue head
//             rsp_ready_i  - consumer takes the head response this cycle
//             rsp_data_o   - read data (0 on error / when empty)
//             rsp_err_o    - word index >= DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module starship_rom_ctrl #(
   parameter int    DATA_W     = 32,
   parameter int    DEPTH      = 2048,
   parameter int    ADDR_W     = 16,
   parameter int    LATENCY    = 1,
   parameter int    FIFO_DEPTH = 2,
   parameter string INIT_FILE  = ""
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o
);

   localparam int OFF_W   = $clog2(DATA_W / 8);
   localparam int IDX_W   = ADDR_W - OFF_W;
   localparam int DEPTH_W = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------------
   generate
      if (LATENCY != 1 && LATENCY != 2) begin : g_chk_latency
         $fatal(1, "starship_rom_ctrl: LATENCY must be 1 or 2");
      end
      if (DATA_W != 32 && DATA_W != 64) begin : g_chk_data_w
         $fatal(1, "starship_rom_ctrl: DATA_W must be 32 or 64");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
         $fatal(1, "starship_rom_ctrl: DEPTH must be a power of two >= 2");
      end
      if (ADDR_W < DEPTH_W + OFF_W) begin : g_chk_addr_w
         $fatal(1, "starship_rom_ctrl: ADDR_W too narrow for DEPTH and DATA_W");
      end
      if (FIFO_DEPTH < 1) begin : g_chk_fifo
         $fatal(1, "starship_rom_ctrl: FIFO_DEPTH must be >= 1");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Word array; contents are fixed once loaded
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] rom_q [DEPTH];

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic               accept;
   logic               fire;
   logic [IDX_W-1:0]   idx;
   logic [DEPTH_W-1:0] word;
   logic               oor;
   logic               unused_addr_bits;

   assign accept = req_valid_i & req_ready_o;
   assign fire   = rsp_valid_o & rsp_ready_i;
   assign idx    = req_addr_i[ADDR_W-1:OFF_W];
   assign word   = idx[DEPTH_W-1:0];
   assign unused_addr_bits = ^req_addr_i[OFF_W-1:0];

   // Any index bit at or above log2(DEPTH) means the request is out of range
   generate
      if (IDX_W > DEPTH_W) begin : g_oor_hi
         assign oor = |idx[IDX_W-1:DEPTH_W];
      end else begin : g_oor_none
         assign oor = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read pipeline: produces the queue write strobe and payload
   // ------------------------------------------------------------------------
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_err;

   generate
      if (LATENCY == 1) begin : g_lat1
         // The queue slot itself is the single read register; the array is
         // only addressed for an accepted in-range request.
         assign wr_en   = accept;
         assign wr_err  = oor;
         assign wr_data = (accept && !oor) ? rom_q[word] : '0;
      end else begin : g_lat2
         logic              s1_valid_q;
         logic              s1_err_q;
         logic [DATA_W-1:0] s1_data_q;

         always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
               s1_valid_q <= 1'b0;
               s1_err_q   <= 1'b0;
               s1_data_q  <= '0;
            end else begin
               s1_valid_q <= accept;
               if (accept) begin
                  s1_err_q  <= oor;
                  s1_data_q <= oor ? '0 : rom_q[word];
               end
            end
         end

         assign wr_en   = s1_valid_q;
         assign wr_err  = s1_err_q;
         assign wr_data = s1_data_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Response queue and credit counter
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic              fifo_err_q  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  out_q;
   logic [CNT_W-1:0]  out_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en, fire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Outstanding = in-flight pipeline entries plus queued entries. Capping it
   // at FIFO_DEPTH reserves a queue slot for every accepted request.
   always_comb begin
      out_d = out_q;
      case ({accept, fire})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (fire)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   // Storage carries no reset; validity is tracked by cnt_q alone
   always_ff @(posedge clock_i) begin
      if (wr_en) begin
         fifo_data_q[wr_ptr_q] <= wr_data;
         fifo_err_q[wr_ptr_q]  <= wr_err;
      end
   end

   assign req_ready_o = (out_q < CNT_W'(FIFO_DEPTH));
   assign rsp_valid_o = (cnt_q != '0);
   // Gating on valid keeps the outputs at zero while the queue is empty
   assign rsp_data_o  = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
   assign rsp_err_o   = rsp_valid_o ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_starship_rom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_starship_rom_ctrl
//  Purpose  : Self-checking bench for starship_rom_ctrl. Instance A uses the
//             default geometry (32-bit, 2048 words, LATENCY=1, FIFO_DEPTH=2).
//             Instance B is 64-bit, 16 words, LATENCY=2, FIFO_DEPTH=3.
//             Expected responses are queued per instance and compared on
//             every response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_starship_rom_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A
   logic        rst_a;
   logic        req_valid_a;
   logic        req_ready_a;
   logic [15:0] req_addr_a;
   logic        rsp_valid_a;
   logic        rsp_ready_a;
   logic [31:0] rsp_data_a;
   logic        rsp_err_a;

   // Instance B
   logic        rst_b;
   logic        req_valid_b;
   logic        req_ready_b;
   logic [7:0]  req_addr_b;
   logic        rsp_valid_b;
   logic        rsp_ready_b;
   logic [63:0] rsp_data_b;
   logic        rsp_err_b;

   starship_rom_ctrl #(
      .DATA_W(32), .DEPTH(2048), .ADDR_W(16), .LATENCY(1), .FIFO_DEPTH(2), .INIT_FILE("")
   ) u_a (
      .clock_i(clk), .reset_i(rst_a),
      .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_addr_i(req_addr_a),
      .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a),
      .rsp_data_o(rsp_data_a), .rsp_err_o(rsp_err_a)
   );

   starship_rom_ctrl #(
      .DATA_W(64), .DEPTH(16), .ADDR_W(8), .LATENCY(2), .FIFO_DEPTH(3), .INIT_FILE("")
   ) u_b (
      .clock_i(clk), .reset_i(rst_b),
      .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_addr_i(req_addr_b),
      .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b),
      .rsp_data_o(rsp_data_b), .rsp_err_o(rsp_err_b)
   );

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t ea;
   exp_t eb;
   int   n_checks = 0;
   int   n_errors = 0;

   // Memory images written into the instances at time zero
   function automatic logic [31:0] word_a(input int i);
      logic [31:0] v;
      v = 32'h1000_0000 + (i * 32'h0001_0101);
      if (i == 5) v = 32'hDEAD_BEEF;
      return v;
   endfunction

   function automatic logic [63:0] word_b(input int i);
      logic [63:0] v;
      v = {32'hB0B0_0000 + i, 32'h1234_5678 ^ (i * 32'h0101_0101)};
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request for a cycle and record its expected response
   task automatic req_a(input logic [15:0] addr, input logic [63:0] d, input logic e);
      req_valid_a = 1'b1;
      req_addr_a  = addr;
      sb_a.push_back('{data: d, err: e});
      tick();
   endtask

   task automatic req_b(input logic [7:0] addr, input logic [63:0] d, input logic e);
      req_valid_b = 1'b1;
      req_addr_b  = addr;
      sb_b.push_back('{data: d, err: e});
      tick();
   endtask

   // Scoreboard monitors: a handshake at the coming edge is decided by now
   always @(negedge clk) begin
      if (rsp_valid_a && rsp_ready_a) begin
         n_checks++;
         assert (sb_a.size() != 0) else begin
            n_errors++;
            $error("FAIL a_unexpected_rsp: observed data %h err %b expected no response",
                   rsp_data_a, rsp_err_a);
         end
         if (sb_a.size() != 0) begin
            ea = sb_a.pop_front();
            chk("a_rsp_data", {32'h0, rsp_data_a}, ea.data);
            chk("a_rsp_err", {63'h0, rsp_err_a}, {63'h0, ea.err});
         end
      end
   end

   always @(negedge clk) begin
      if (rsp_valid_b && rsp_ready_b) begin
         n_checks++;
         assert (sb_b.size() != 0) else begin
            n_errors++;
            $error("FAIL b_unexpected_rsp: observed data %h err %b expected no response",
                   rsp_data_b, rsp_err_b);
         end
         if (sb_b.size() != 0) begin
            eb = sb_b.pop_front();
            chk("b_rsp_data", rsp_data_b, eb.data);
            chk("b_rsp_err", {63'h0, rsp_err_b}, {63'h0, eb.err});
         end
      end
   end

   initial begin
      rst_a = 1'b1;  rst_b = 1'b1;
      req_valid_a = 1'b0; req_addr_a = '0; rsp_ready_a = 1'b0;
      req_valid_b = 1'b0; req_addr_b = '0; rsp_ready_b = 1'b0;
      for (int i = 0; i < 2048; i++) u_a.rom_q[i] = word_a(i);
      for (int i = 0; i < 16; i++)   u_b.rom_q[i] = word_b(i);

      // Reset state
      repeat (2) tick();
      chk("a_rst_req_ready", {63'h0, req_ready_a}, 64'd1);
      chk("a_rst_rsp_valid", {63'h0, rsp_valid_a}, 64'd0);
      chk("a_rst_rsp_data",  {32'h0, rsp_data_a},  64'd0);
      chk("a_rst_rsp_err",   {63'h0, rsp_err_a},   64'd0);
      chk("b_rst_req_ready", {63'h0, req_ready_b}, 64'd1);
      chk("b_rst_rsp_valid", {63'h0, rsp_valid_b}, 64'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // Single read of word 5, response one cycle after accept
      rsp_ready_a = 1'b1;
      req_a(16'h0014, 64'hDEAD_BEEF, 1'b0);
      req_valid_a = 1'b0;
      chk("a_lat1_valid", {63'h0, rsp_valid_a}, 64'd1);
      tick();
      chk("a_lat1_drained", {63'h0, rsp_valid_a}, 64'd0);

      // Back-to-back requests with a free-running consumer
      for (int k = 0; k < 3; k++) begin
         chk("a_b2b_req_ready", {63'h0, req_ready_a}, 64'd1);
         req_a(16'(k * 4), {32'h0, word_a(k)}, 1'b0);
         chk("a_b2b_rsp_valid", {63'h0, rsp_valid_a}, 64'd1);
      end
      req_valid_a = 1'b0;
      repeat (2) tick();

      // Backpressure: two accepts fill the credits, head held stable
      rsp_ready_a = 1'b0;
      req_a(16'h0040, {32'h0, word_a(16)}, 1'b0);
      req_a(16'h0044, {32'h0, word_a(17)}, 1'b0);
      req_valid_a = 1'b0;
      chk("a_bp_req_ready_low", {63'h0, req_ready_a}, 64'd0);
      chk("a_bp_rsp_valid",     {63'h0, rsp_valid_a}, 64'd1);
      for (int k = 0; k < 3; k++) begin
         chk("a_bp_hold_data", {32'h0, rsp_data_a}, {32'h0, word_a(16)});
         chk("a_bp_hold_err",  {63'h0, rsp_err_a},  64'd0);
         tick();
      end
      rsp_ready_a = 1'b1;
      tick();
      chk("a_bp_req_ready_back", {63'h0, req_ready_a}, 64'd1);
      repeat (2) tick();

      // Out-of-range, sub-word address bits, last word
      req_a(16'h2000, 64'h0, 1'b1);
      req_a(16'h0000, {32'h0, word_a(0)}, 1'b0);
      req_a(16'h0017, {32'h0, word_a(5)}, 1'b0);
      req_a(16'h1FFC, {32'h0, word_a(2047)}, 1'b0);
      req_a(16'hFFFC, 64'h0, 1'b1);
      req_valid_a = 1'b0;
      repeat (3) tick();

      // Instance B: two-cycle latency, 64-bit word 1 from byte address 0x0B
      rsp_ready_b = 1'b1;
      req_b(8'h0B, word_b(1), 1'b0);
      req_valid_b = 1'b0;
      chk("b_lat2_not_early", {63'h0, rsp_valid_b}, 64'd0);
      tick();
      chk("b_lat2_valid", {63'h0, rsp_valid_b}, 64'd1);
      tick();
      req_b(8'h80, 64'h0, 1'b1);
      req_b(8'h78, word_b(15), 1'b0);
      req_valid_b = 1'b0;
      repeat (4) tick();

      // Reset with two queued responses and one in flight
      rsp_ready_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("b_fill_req_ready", {63'h0, req_ready_b}, 64'd1);
         req_valid_b = 1'b1;
         req_addr_b  = 8'(k * 8);
         tick();
      end
      req_valid_b = 1'b0;
      chk("b_fill_rsp_valid", {63'h0, rsp_valid_b}, 64'd1);
      #2;
      rst_b = 1'b1;
      #1;
      chk("b_async_rst_valid", {63'h0, rsp_valid_b}, 64'd0);
      chk("b_async_rst_data",  rsp_data_b, 64'd0);
      tick();
      rst_b = 1'b0;
      rsp_ready_b = 1'b1;
      chk("b_post_rst_ready", {63'h0, req_ready_b}, 64'd1);
      repeat (4) tick();
      chk("b_no_stale", {63'h0, rsp_valid_b}, 64'd0);
      req_b(8'h10, word_b(2), 1'b0);
      req_valid_b = 1'b0;
      repeat (3) tick();

      // Every recorded expectation must have been consumed
      for (int k = 0; k < 20 && (sb_a.size() != 0 || sb_b.size() != 0); k++) tick();
      chk("a_sb_drained", 64'(sb_a.size()), 64'd0);
      chk("b_sb_drained", 64'(sb_b.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
